// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : PC-driven instruction fetch from a combinational ROM into a
//            registered valid/ready output slot, with redirect, HALT and a
//            saturating accepted-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter int                  ADDR_W      = 8,
    parameter int                  INSTR_W     = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
    parameter logic [3:0]          HALT_OPCODE = 4'b1111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

    state_t               r_state,     w_state_nxt;
    logic [ADDR_W-1:0]    r_pc,        w_pc_nxt;
    logic                 r_valid,     w_valid_nxt;
    logic [INSTR_W-1:0]   r_instr,     w_instr_nxt;
    logic [ADDR_W-1:0]    r_out_pc,    w_out_pc_nxt;
    logic                 r_halted,    w_halted_nxt;
    logic [15:0]          r_count,     w_count_nxt;

    logic                 w_slot_free;
    logic                 w_is_halt;
    logic                 w_accept;

    assign w_slot_free = !r_valid || out_ready;
    assign w_is_halt   = (imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);
    // A redirect drops the slot, so a simultaneous handshake is not counted.
    assign w_accept    = r_valid && out_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_out_pc <= '0;
            r_halted <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_valid  <= w_valid_nxt;
            r_instr  <= w_instr_nxt;
            r_out_pc <= w_out_pc_nxt;
            r_halted <= w_halted_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_valid_nxt  = r_valid;
        w_instr_nxt  = r_instr;
        w_out_pc_nxt = r_out_pc;
        w_halted_nxt = r_halted;
        w_count_nxt  = r_count;

        if (w_accept && (r_count != c_COUNT_MAX)) begin
            w_count_nxt = r_count + 16'd1;
        end

        unique case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                end
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_valid_nxt = 1'b0;
                end else if (w_slot_free) begin
                    w_instr_nxt  = imem_instr;
                    w_out_pc_nxt = r_pc;
                    w_valid_nxt  = 1'b1;
                    if (w_is_halt) begin
                        // PC parks on the HALT so imem_addr reports where fetch stopped.
                        w_state_nxt  = S_HALT;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = r_pc + ADDR_W'(1);
                    end
                end
            end

            S_HALT: begin
                if (redirect_valid) begin
                    w_pc_nxt     = redirect_pc;
                    w_valid_nxt  = 1'b0;
                    w_halted_nxt = 1'b0;
                    w_state_nxt  = S_RUN;
                end else begin
                    if (r_valid && out_ready) begin
                        w_valid_nxt = 1'b0;
                    end
                    if (start && !r_valid) begin
                        w_pc_nxt     = RESET_PC;
                        w_halted_nxt = 1'b0;
                        w_state_nxt  = S_RUN;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_addr   = r_pc;
    assign out_valid   = r_valid;
    assign out_instr   = r_instr;
    assign out_pc      = r_out_pc;
    assign halted      = r_halted;
    assign fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed test-plan scenarios plus randomized traffic checked
//            against a cycle-level behavioural model of the fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] rom [0:255];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: mode 0=idle, 1=running, 2=halted
    int          m_mode;
    int          m_pc;
    bit          m_valid;
    logic [15:0] m_instr;
    int          m_out_pc;
    bit          m_halted;
    int          m_count;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    assign imem_instr = rom[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        bit take;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_valid = 0; m_instr = 16'h0;
            m_out_pc = 0; m_halted = 0; m_count = 0;
            return;
        end
        take = m_valid && out_ready && !redirect_valid;
        if (take && m_count < 65535) m_count = m_count + 1;
        case (m_mode)
            0: begin
                if (redirect_valid) m_pc = int'(redirect_pc);
                if (start) m_mode = 1;
            end
            1: begin
                if (redirect_valid) begin
                    m_pc = int'(redirect_pc);
                    m_valid = 0;
                end else if (!m_valid || out_ready) begin
                    m_instr  = rom[m_pc];
                    m_out_pc = m_pc;
                    m_valid  = 1;
                    if (m_instr[15:12] == 4'hF) begin
                        m_mode = 2;
                        m_halted = 1;
                    end else begin
                        m_pc = (m_pc + 1) % 256;
                    end
                end
            end
            default: begin
                if (redirect_valid) begin
                    m_pc = int'(redirect_pc);
                    m_valid = 0;
                    m_halted = 0;
                    m_mode = 1;
                end else begin
                    bit restart;
                    restart = start && !m_valid;
                    if (m_valid && out_ready) m_valid = 0;
                    if (restart) begin
                        m_pc = 0;
                        m_halted = 0;
                        m_mode = 1;
                    end
                end
            end
        endcase
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("imem_addr", 32'(imem_addr), 32'(m_pc));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_instr", 32'(out_instr), 32'(m_instr));
        check_eq("out_pc", 32'(out_pc), 32'(m_out_pc));
        check_eq("halted", 32'(halted), 32'(m_halted));
        check_eq("fetch_count", 32'(fetch_count), 32'(m_count));
    endtask

    task automatic cyc(input bit s, input bit rv, input logic [7:0] rp, input bit rdy);
        rst = 1'b0;
        start = s;
        redirect_valid = rv;
        redirect_pc = rp;
        out_ready = rdy;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h4105;
        rom[1] = 16'h420A;
        rom[2] = 16'h0312;
        rom[3] = 16'h5300;
        rom[4] = 16'hF000;
    endtask

    logic [15:0] exp_instr [0:4];

    initial begin
        exp_instr[0] = 16'h4105;
        exp_instr[1] = 16'h420A;
        exp_instr[2] = 16'h0312;
        exp_instr[3] = 16'h5300;
        exp_instr[4] = 16'hF000;

        load_program();
        do_reset();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'd0);
        check_eq("rst_count", 32'(fetch_count), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);

        // Straight-line program to HALT
        cyc(1, 0, 8'd0, 1);
        check_eq("start_lat_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'd0, 1);
            check_eq("seq_valid", 32'(out_valid), 32'd1);
            check_eq("seq_pc", 32'(out_pc), 32'(i));
            check_eq("seq_instr", 32'(out_instr), 32'(exp_instr[i]));
        end
        cyc(0, 0, 8'd0, 1);
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_valid", 32'(out_valid), 32'd0);
        check_eq("halt_count", 32'(fetch_count), 32'd5);
        check_eq("halt_addr", 32'(imem_addr), 32'd4);

        // Restart after drained HALT, then stall on (1,0x420A)
        cyc(1, 0, 8'd0, 1);
        check_eq("restart_halted", 32'(halted), 32'd0);
        cyc(0, 0, 8'd0, 1);
        check_eq("restart_pc", 32'(out_pc), 32'd0);
        check_eq("restart_instr", 32'(out_instr), 32'h4105);
        cyc(0, 0, 8'd0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 8'd0, 0);
            check_eq("stall_pc", 32'(out_pc), 32'd1);
            check_eq("stall_instr", 32'(out_instr), 32'h420A);
            check_eq("stall_addr", 32'(imem_addr), 32'd2);
        end
        cyc(0, 0, 8'd0, 1);
        check_eq("resume_pc", 32'(out_pc), 32'd2);
        cyc(0, 0, 8'd0, 1);
        check_eq("resume_pc2", 32'(out_pc), 32'd3);

        // Redirect flushes the slot holding (1,0x420A)
        do_reset();
        cyc(1, 0, 8'd0, 1);
        cyc(0, 0, 8'd0, 1);
        cyc(0, 0, 8'd0, 1);
        check_eq("pre_redir_pc", 32'(out_pc), 32'd1);
        cyc(0, 1, 8'd3, 1);
        check_eq("redir_valid", 32'(out_valid), 32'd0);
        check_eq("redir_count", 32'(fetch_count), 32'd1);
        cyc(0, 0, 8'd0, 1);
        check_eq("redir_out_pc", 32'(out_pc), 32'd3);
        check_eq("redir_out_instr", 32'(out_instr), 32'h5300);
        check_eq("redir_count2", 32'(fetch_count), 32'd1);

        // PC wrap-around on an all-NOP ROM
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        do_reset();
        cyc(1, 1, 8'd254, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 8'd0, 1);
            check_eq("wrap_pc", 32'(out_pc), 32'((254 + i) % 256));
        end

        // Reset while a slot is valid
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_addr", 32'(imem_addr), 32'd0);
        check_eq("midrst_count", 32'(fetch_count), 32'd0);
        check_eq("midrst_halted", 32'(halted), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 9) == 0) ? {4'hF, 12'($urandom)} : 16'($urandom);
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            start          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 8'($urandom);
            out_ready      = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
